dcache_arbiter: RTL

- Two-requester arbiter and sequencer for the single-ported, byte-addressed data cache/memory model.
- Accepts load/store requests from port 0 (load unit) and port 1 (store unit) using a valid/ready handshake, with round-robin arbitration.
- Drives one memory transaction at a time: address, byte-lane write enables and write data.
- Waits for the memory's delayed valid, then returns a one-cycle response (read data or write ack) to the requester that issued it.

---
 rtl/dcache_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dcache_arbiter.sv
// dcache_arbiter: two-port round-robin arbiter and sequencer for a single-ported,
// byte-addressed data memory. One transaction is in flight at a time, and a
// one-cycle response goes back to the port that issued it.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   p0_req_*             load unit request (valid/ready, addr, byte we, wdata)
//   p1_req_*             store unit request (same layout)
//   rsp_valid[1:0]       one-hot response pulse, bit i = port i
//   rsp_data, rsp_err    read data (0 for writes), timeout flag
//   mem_address/we/data_write  registered memory command
//   mem_data_read, mem_valid   memory return path
//   busy                 high whenever a transaction is in progress
module dcache_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic [31:0] p0_req_addr,
    input  logic [3:0]  p0_req_we,
    input  logic [31:0] p0_req_wdata,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic [31:0] p1_req_addr,
    input  logic [3:0]  p1_req_we,
    input  logic [31:0] p1_req_wdata,

    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,

    output logic [31:0] mem_address,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_data_write,
    input  logic [31:0] mem_data_read,
    input  logic        mem_valid,

    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e           state_q;
    logic             last_grant_q;  // port granted most recently
    logic             id_q;          // port owning the transaction in flight
    logic             is_write_q;
    logic [CNT_W-1:0] cnt_q;

    logic grant0;
    logic grant1;

    // Under contention the port that did not win last time gets the grant.
    always_comb begin
        grant0 = p0_req_valid && (!p1_req_valid || last_grant_q);
        grant1 = p1_req_valid && (!p0_req_valid || !last_grant_q);
    end

    assign p0_req_ready = !rst && (state_q == StIdle) && grant0;
    assign p1_req_ready = !rst && (state_q == StIdle) && grant1;
    assign busy         = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            mem_address    <= '0;
            mem_we         <= '0;
            mem_data_write <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            last_grant_q   <= 1'b1;
            id_q           <= 1'b0;
            is_write_q     <= 1'b0;
            cnt_q          <= '0;
        end else begin
            // Response outputs are single-cycle pulses.
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (p0_req_ready || p1_req_ready) begin
                        mem_address    <= grant1 ? p1_req_addr  : p0_req_addr;
                        mem_we         <= grant1 ? p1_req_we    : p0_req_we;
                        mem_data_write <= grant1 ? p1_req_wdata : p0_req_wdata;
                        is_write_q     <= grant1 ? (|p1_req_we) : (|p0_req_we);
                        id_q           <= grant1;
                        last_grant_q   <= grant1;
                        state_q        <= StIssue;
                    end
                end
                StIssue: begin
                    // Write enables live for exactly this cycle; mem_valid is
                    // stale here because the address just changed.
                    mem_we  <= '0;
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (mem_valid) begin
                        rsp_valid[id_q] <= 1'b1;
                        rsp_data        <= is_write_q ? 32'h0 : mem_data_read;
                        state_q         <= StIdle;
                    end else if (cnt_q == TimeoutCnt) begin
                        rsp_valid[id_q] <= 1'b1;
                        rsp_err         <= 1'b1;
                        state_q         <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
